// File: rtl/fft_butterfly_scheduler_pkg.sv
// fft_sched_pkg: shared FSM state type, default sizing and bit-reversal helper for the FFT scheduler
package fft_sched_pkg;
  typedef enum logic [1:0] {LOAD, ISSUE, WAIT, UNLOAD} state_t;
  localparam int N_DEFAULT = 8;
  localparam int LOG2N = $clog2(N_DEFAULT);
  localparam int TW_W = (LOG2N > 1) ? LOG2N - 1 : 1;
  function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nbits; i++) r[i] = value[nbits - 1 - i];
    return r;
  endfunction
endpackage

// File: rtl/fft_butterfly_scheduler_addr_gen.sv
// fft_addr_gen: combinational (stage, k) -> (a, b, twiddle index) for radix-2 DIT butterflies
module fft_addr_gen #(
  parameter int LG = 3,
  localparam int SW = (LG > 1) ? $clog2(LG) : 1,
  localparam int KW = (LG > 1) ? LG - 1 : 1
) (
  input  logic [SW-1:0] stage,
  input  logic [KW-1:0] k,
  output logic [LG-1:0] a,
  output logic [LG-1:0] b,
  output logic [KW-1:0] tw_idx
);
  logic [LG-1:0] kk, half, low;
  always_comb begin
    kk = LG'(k);
    half = LG'(1) << stage;
    low = kk & (half - LG'(1));
    a = ((kk >> stage) << (32'(stage) + 32'd1)) | low;
    b = a + half;
    tw_idx = KW'(low << (LG - 1 - int'(stage)));
  end
endmodule

// File: rtl/fft_butterfly_scheduler.sv
// fft_butterfly_scheduler: runs an N-point radix-2 DIT FFT through one shared external butterfly
module fft_butterfly_scheduler
  import fft_sched_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8,
  localparam int LG = $clog2(N_SAMPLES),
  localparam int TWW = (LG > 1) ? LG - 1 : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] recv_msg_real,
  input  logic [BIT_WIDTH-1:0] recv_msg_imag,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic [BIT_WIDTH-1:0] bf_ar,
  output logic [BIT_WIDTH-1:0] bf_ac,
  output logic [BIT_WIDTH-1:0] bf_br,
  output logic [BIT_WIDTH-1:0] bf_bc,
  output logic [TWW-1:0]       bf_tw_idx,
  output logic                 bf_req_val,
  input  logic                 bf_req_rdy,
  input  logic [BIT_WIDTH-1:0] bf_cr,
  input  logic [BIT_WIDTH-1:0] bf_cc,
  input  logic [BIT_WIDTH-1:0] bf_dr,
  input  logic [BIT_WIDTH-1:0] bf_dc,
  input  logic                 bf_resp_val,
  output logic                 bf_resp_rdy,
  output logic [BIT_WIDTH-1:0] send_msg_real,
  output logic [BIT_WIDTH-1:0] send_msg_imag,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic                 busy
);
  localparam int SW = (LG > 1) ? $clog2(LG) : 1;
  state_t state;
  logic [LG-1:0] load_cnt, unload_cnt, load_addr, a, b;
  logic [SW-1:0] stage;
  logic [TWW-1:0] k;
  logic last_k, last_stage;
  logic [BIT_WIDTH-1:0] mem_r [N_SAMPLES];
  logic [BIT_WIDTH-1:0] mem_i [N_SAMPLES];
  fft_addr_gen #(.LG(LG)) u_addr (.stage(stage), .k(k), .a(a), .b(b), .tw_idx(bf_tw_idx));
  assign load_addr = LG'(bit_reverse(32'(load_cnt), LG));
  assign last_k = k == TWW'(N_SAMPLES / 2 - 1);
  assign last_stage = stage == SW'(LG - 1);
  assign recv_rdy = state == LOAD;
  assign bf_req_val = state == ISSUE;
  assign bf_resp_rdy = state == WAIT;
  assign send_val = state == UNLOAD;
  assign busy = state == ISSUE || state == WAIT;
  assign bf_ar = mem_r[a];
  assign bf_ac = mem_i[a];
  assign bf_br = mem_r[b];
  assign bf_bc = mem_i[b];
  assign send_msg_real = mem_r[unload_cnt];
  assign send_msg_imag = mem_i[unload_cnt];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      load_cnt <= '0;
      unload_cnt <= '0;
      stage <= '0;
      k <= '0;
    end else begin
      case (state)
        LOAD: if (recv_val) begin
          load_cnt <= load_cnt + 1'b1;
          if (load_cnt == LG'(N_SAMPLES - 1)) state <= ISSUE;
        end
        ISSUE: if (bf_req_rdy) state <= WAIT;
        WAIT: if (bf_resp_val) begin
          k <= last_k ? '0 : k + 1'b1;
          stage <= !last_k ? stage : last_stage ? '0 : stage + 1'b1;
          state <= last_k && last_stage ? UNLOAD : ISSUE;
        end
        UNLOAD: if (send_rdy) begin
          unload_cnt <= unload_cnt + 1'b1;
          if (unload_cnt == LG'(N_SAMPLES - 1)) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && state == LOAD && recv_val) begin
      mem_r[load_addr] <= recv_msg_real;
      mem_i[load_addr] <= recv_msg_imag;
    end
    if (!reset && state == WAIT && bf_resp_val) begin
      mem_r[a] <= bf_cr;
      mem_i[a] <= bf_cc;
      mem_r[b] <= bf_dr;
      mem_i[b] <= bf_dc;
    end
  end
endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// tb_fft_butterfly_scheduler: directed frames against a Q16.16 butterfly model with stalls and resets
module tb_fft_butterfly_scheduler;
  import fft_sched_pkg::*;
  localparam int BW = 32;
  localparam logic [31:0] ONE = 32'h0001_0000;
  localparam logic [31:0] H = 32'd46341;
  logic clk = 1'b0;
  logic reset;
  logic [BW-1:0] recv_msg_real, recv_msg_imag, bf_ar, bf_ac, bf_br, bf_bc;
  logic [BW-1:0] bf_cr, bf_cc, bf_dr, bf_dc, send_msg_real, send_msg_imag;
  logic [TW_W-1:0] bf_tw_idx;
  logic recv_val, recv_rdy, bf_req_val, bf_req_rdy, bf_resp_val, bf_resp_rdy;
  logic send_val, send_rdy, busy;
  fft_butterfly_scheduler #(.BIT_WIDTH(BW), .N_SAMPLES(8)) dut (
    .clk(clk), .reset(reset),
    .recv_msg_real(recv_msg_real), .recv_msg_imag(recv_msg_imag), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .bf_ar(bf_ar), .bf_ac(bf_ac), .bf_br(bf_br), .bf_bc(bf_bc), .bf_tw_idx(bf_tw_idx),
    .bf_req_val(bf_req_val), .bf_req_rdy(bf_req_rdy),
    .bf_cr(bf_cr), .bf_cc(bf_cc), .bf_dr(bf_dr), .bf_dc(bf_dc),
    .bf_resp_val(bf_resp_val), .bf_resp_rdy(bf_resp_rdy),
    .send_msg_real(send_msg_real), .send_msg_imag(send_msg_imag), .send_val(send_val), .send_rdy(send_rdy),
    .busy(busy)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [31:0] in_r [8], in_i [8], exp_r [8], exp_i [8], out_r [8], out_i [8];
  logic [11:0] bf_log [16];
  logic [11:0] exp_seq [12] = '{12'h010, 12'h230, 12'h450, 12'h670,
                                12'h020, 12'h132, 12'h460, 12'h572,
                                12'h040, 12'h151, 12'h262, 12'h373};
  logic signed [31:0] twr [4] = '{32'sd65536, 32'sd46341, 32'sd0, -32'sd46341};
  logic signed [31:0] twi [4] = '{32'sd0, -32'sd46341, -32'sd65536, -32'sd46341};
  bit stub;
  int req_stall, resp_delay;
  int bf_count = 0;
  int stall_err = 0;
  int busy_cyc = 0;
  bit bf_idle = 1'b1;
  always @(negedge clk) if (busy) busy_cyc++;
  // Butterfly stand-in: stub (c=a, d=b) or Q16.16 c = a + W*b, d = a - W*b
  initial begin : bfm
    logic [4*BW+TW_W-1:0] op;
    logic signed [31:0] ar, ac, br, bc;
    longint pr, pi;
    int j;
    bf_req_rdy = 1'b0;
    bf_resp_val = 1'b0;
    {bf_cr, bf_cc, bf_dr, bf_dc} = '0;
    @(posedge clk); #1;
    forever begin
      if (bf_req_val && !reset) begin
        bf_idle = 1'b0;
        op = {bf_ar, bf_ac, bf_br, bf_bc, bf_tw_idx};
        for (int i = 0; i < req_stall; i++) begin
          @(posedge clk); #1;
          if ({bf_ar, bf_ac, bf_br, bf_bc, bf_tw_idx} != op || !bf_req_val) stall_err++;
        end
        ar = bf_ar; ac = bf_ac; br = bf_br; bc = bf_bc; j = int'(bf_tw_idx);
        if (bf_count < 16) bf_log[bf_count] = {bf_ar[3:0], bf_br[3:0], 2'b00, bf_tw_idx};
        bf_count++;
        bf_req_rdy = 1'b1;
        @(posedge clk); #1;
        bf_req_rdy = 1'b0;
        repeat (resp_delay) begin @(posedge clk); #1; end
        pr = (longint'(br) * longint'(twr[j]) - longint'(bc) * longint'(twi[j])) >>> 16;
        pi = (longint'(br) * longint'(twi[j]) + longint'(bc) * longint'(twr[j])) >>> 16;
        bf_cr = stub ? ar : ar + 32'(pr);
        bf_cc = stub ? ac : ac + 32'(pi);
        bf_dr = stub ? br : ar - 32'(pr);
        bf_dc = stub ? bc : ac - 32'(pi);
        bf_resp_val = 1'b1;
        @(posedge clk); #1;
        bf_resp_val = 1'b0;
        bf_idle = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic load_frame();
    int t;
    for (int n = 0; n < 8; n++) begin
      t = 0;
      while (!recv_rdy && t < 1000) begin step(); t++; end
      chk($sformatf("load_rdy%0d", n), recv_rdy, 1);
      recv_val = 1'b1;
      recv_msg_real = in_r[n];
      recv_msg_imag = in_i[n];
      step();
    end
    recv_val = 1'b0;
  endtask
  task automatic unload_frame(input bit toggle);
    int t;
    logic [31:0] hr, hi;
    for (int n = 0; n < 8; n++) begin
      t = 0;
      while (!send_val && t < 2000) begin step(); t++; end
      chk($sformatf("send_val%0d", n), send_val, 1);
      if (toggle && n % 2 == 1) begin
        send_rdy = 1'b0;
        hr = send_msg_real;
        hi = send_msg_imag;
        step();
        chk($sformatf("send_stable%0d", n), {send_msg_real, send_msg_imag}, {hr, hi});
      end
      out_r[n] = send_msg_real;
      out_i[n] = send_msg_imag;
      send_rdy = 1'b1;
      step();
      send_rdy = 1'b0;
    end
  endtask
  task automatic check_bins(input string name);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_bin%0d_re", name, i), out_r[i], exp_r[i]);
      chk($sformatf("%s_bin%0d_im", name, i), out_i[i], exp_i[i]);
    end
  endtask
  task automatic run_frame(input string name, input bit toggle);
    int base;
    base = bf_count;
    load_frame();
    unload_frame(toggle);
    chk({name, "_bf_count"}, 64'(bf_count - base), 12);
    check_bins(name);
  endtask
  task automatic set_impulse(input int pos);
    in_r = '{default: '0};
    in_i = '{default: '0};
    in_r[pos] = ONE;
    exp_i = pos == 0 ? '{default: '0} : '{32'd0, -H, -ONE, -H, 32'd0, H, ONE, H};
    exp_r = pos == 0 ? '{default: ONE} : '{ONE, H, 32'd0, -H, -ONE, -H, 32'd0, H};
  endtask
  task automatic set_constant();
    in_r = '{default: ONE};
    in_i = '{default: '0};
    exp_r = '{default: '0};
    exp_i = '{default: '0};
    exp_r[0] = 32'h0008_0000;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end
  initial begin
    int c0, s0, t, base;
    reset = 1'b1;
    recv_val = 1'b0;
    recv_msg_real = '0;
    recv_msg_imag = '0;
    send_rdy = 1'b0;
    stub = 1'b1;
    req_stall = 0;
    resp_delay = 0;
    repeat (2) step();
    chk("rst_recv_rdy", recv_rdy, 1);
    chk("rst_bf_req_val", bf_req_val, 0);
    chk("rst_bf_resp_rdy", bf_resp_rdy, 0);
    chk("rst_send_val", send_val, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tw_idx", bf_tw_idx, 0);
    reset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      in_r[n] = bit_reverse(32'(n), 3);
      in_i[n] = 32'h100 + in_r[n];
      exp_r[n] = 32'(n);
      exp_i[n] = 32'h100 + 32'(n);
    end
    c0 = busy_cyc;
    run_frame("addr", 1'b0);
    chk("compute_cycles", 64'(busy_cyc - c0), 24);
    for (int i = 0; i < 12; i++) chk($sformatf("addr_seq%0d", i), bf_log[i], exp_seq[i]);
    stub = 1'b0;
    set_impulse(0);
    run_frame("impulse0", 1'b0);
    set_impulse(1);
    run_frame("impulse1", 1'b0);
    set_constant();
    run_frame("const", 1'b0);
    req_stall = 3;
    resp_delay = 4;
    s0 = stall_err;
    set_impulse(1);
    run_frame("stall", 1'b1);
    chk("stall_operands_stable", 64'(stall_err - s0), 0);
    req_stall = 0;
    resp_delay = 3;
    set_impulse(1);
    base = bf_count;
    load_frame();
    t = 0;
    while (!(bf_count - base == 5 && bf_resp_rdy) && t < 500) begin step(); t++; end
    chk("reach_wait_stage1", bf_resp_rdy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_recv_rdy", recv_rdy, 1);
    chk("midrst_busy", busy, 0);
    t = 0;
    while (!bf_idle && t < 100) begin step(); t++; end
    chk("midrst_bf_idle", bf_idle, 1);
    resp_delay = 0;
    set_impulse(0);
    run_frame("after_rst", 1'b0);
    set_constant();
    load_frame();
    unload_frame(1'b0);
    chk("b2b_recv_rdy", recv_rdy, 1);
    check_bins("b2b_first");
    set_impulse(0);
    run_frame("b2b_second", 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_butterfly_scheduler.md
# fft_butterfly_scheduler

Sequencer that computes a full N-point radix-2 DIT FFT by time-multiplexing one external butterfly unit across all log2(N) stages and N/2 butterflies per stage. It is the area-lean alternative to the fully unrolled per-stage datapath. It contains:
- a serial load port,
- an N-entry complex sample register file,
- a val/rdy request/response pair to a single butterfly,
- a serial unload port.

## Interface
- BIT_WIDTH, 32, width of each real/imag word (fixed point)
- N_SAMPLES, 8, FFT size; power of two, ≥ 2
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- recv_msg_real / recv_msg_imag  in  BIT_WIDTH  input sample, natural order
- recv_val  in  1  input sample valid
- recv_rdy  out  1  ready to load a sample
- bf_ar, bf_ac, bf_br, bf_bc  out  BIT_WIDTH each  butterfly operands a, b
- bf_tw_idx  out  max(1,log2(N_SAMPLES/2))  twiddle index j, selecting W_N^j
- bf_req_val  out  1  operands valid
- bf_req_rdy  in  1  butterfly accepts operands
- bf_cr, bf_cc, bf_dr, bf_dc  in  BIT_WIDTH each  butterfly results c = a + W·b, d = a − W·b
- bf_resp_val  in  1  results valid
- bf_resp_rdy  out  1  scheduler accepts results
- send_msg_real / send_msg_imag  out  BIT_WIDTH  output bin, natural order
- send_val  out  1  output bin valid
- send_rdy  in  1  consumer ready
- busy  out  1  high in ISSUE/WAIT

## Operation
- The FSM has four states: LOAD, ISSUE, WAIT, UNLOAD.
- **LOAD**
  - recv_rdy = 1.
  - On each recv_val && recv_rdy, store the sample at address bitrev(load_cnt), then increment load_cnt.
  - After sample N−1, go to ISSUE with stage = 0 and k = 0.
- **Address generation** (stage s, butterfly k):
  - half = 1 << s
  - a = ((k >> s) << (s+1)) | (k & (half−1))
  - b = a + half
  - bf_tw_idx = (k & (half−1)) << (log2N − 1 − s)
- **ISSUE**
  - Drive mem[a], mem[b] and bf_tw_idx; bf_req_val = 1.
  - On bf_req_rdy, go to WAIT.
  - Operands and index stay stable while stalled.
- **WAIT**
  - bf_resp_rdy = 1.
  - On bf_resp_val, write c → mem[a] and d → mem[b] in the same cycle.
  - Then advance k. On k wrap, advance stage.
  - After the last butterfly of stage log2N−1, go to UNLOAD. Otherwise go to ISSUE.
- **UNLOAD**
  - send_val = 1; send_msg = mem[unload_cnt].
  - On send_rdy, increment unload_cnt.
  - After bin N−1, go to LOAD.
- Exactly one butterfly is in flight at a time, so there are no read-after-write hazards.
- No arithmetic is done here. Scaling and rounding belong to the butterfly.

## Timing
- **Reset values:**
  - state = LOAD; all counters = 0.
  - recv_rdy = 1, bf_req_val = 0, bf_resp_rdy = 0, send_val = 0, busy = 0.
  - bf_tw_idx = 0.
  - The register file is not cleared.
- **Output timing:**
  - All handshake outputs are pure functions of the registered state: recv_rdy, bf_req_val, bf_resp_rdy, send_val, busy.
  - No input reaches an output combinationally.
- **Throughput and latency:**
  - Load: N cycles minimum.
  - Per butterfly: 1 cycle (ISSUE) + butterfly latency L (≥ 1) in WAIT.
  - Compute: (N/2)·log2N·(1+L) cycles; unload: N cycles.
  - A new frame's first sample is accepted the cycle after the last bin's handshake.
- **Ignored and masked inputs:**
  - recv_val outside LOAD is ignored.
  - bf_resp_val outside WAIT is ignored.
  - bf_req_rdy is don't-care when bf_req_val = 0.
- **Reset mid-frame:** synchronous reset in any state aborts the frame and returns to LOAD the next cycle. The butterfly shares clk/reset, so no stale response survives.
- **Stalls:** send_rdy = 0 holds send_msg stable.

## Structure
- Package fft_sched_pkg holds:
  - the state_t enum {LOAD, ISSUE, WAIT, UNLOAD};
  - the function bit_reverse(value, nbits);
  - localparams LOG2N and the TW_W width.
- One sub-module, fft_addr_gen, is purely combinational: (stage, k) → (a, b, tw_idx). It is unit-testable on its own.
- The register file is built from flops with 2 read ports and 2 write ports.

## Test plan
- **Address sequence, N=8, stub butterfly (L=1):** the expected (a,b,tw) sequence is:
  - stage 0: (0,1,0), (2,3,0), (4,5,0), (6,7,0)
  - stage 1: (0,2,0), (1,3,2), (4,6,0), (5,7,2)
  - stage 2: (0,4,0), (1,5,1), (2,6,2), (3,7,3)
- **Impulse, real butterfly model, Q16.16:** input x[0] = 0x00010000, rest 0 → all 8 bins real = 0x00010000, imag = 0.
- **Constant input:** all x = 0x00010000 → bin0 real = 0x00080000; bins 1–7 = 0 (±1 LSB).
- **Backpressure:**
  - Hold bf_req_rdy low for 3 cycles, bf_resp_val late by 4 cycles, and send_rdy toggling.
  - Required: operands stable while stalled, no duplicate or lost butterflies, same bins as the unstalled run.
- **Reset in WAIT during stage 1:**
  - Next cycle recv_rdy = 1, busy = 0.
  - A fresh impulse frame then yields correct bins.
- **Back-to-back frames:** the second frame's first sample is accepted the cycle after the first frame's bin 7 handshake, and its results are independent of the first frame.
